// File: rtl/pipe_id_ex_nlane_if.sv
// ID/EX bundle handshake interface: ID side in_*, EX side out_*.
// Sideband controls (kill_mask, redirect, flush) travel with the ID side.
interface pipe_id_ex_nlane_if #(
  parameter int LANES = 2,
  parameter int PAY_W = 118
);
  logic [LANES-1:0]       in_valid;
  logic [LANES*PAY_W-1:0] in_pay;
  logic                   in_ready;
  logic [LANES-1:0]       kill_mask;
  logic [1:0]             redirect;
  logic                   flush;
  logic [LANES-1:0]       out_valid;
  logic [LANES*PAY_W-1:0] out_pay;
  logic                   out_ready;
  logic [1:0]             occ;

  modport master (
    output in_valid, in_pay, kill_mask,
    output redirect, flush, out_ready,
    input  in_ready, out_valid, out_pay, occ
  );

  modport slave (
    input  in_valid, in_pay, kill_mask,
    input  redirect, flush, out_ready,
    output in_ready, out_valid, out_pay, occ
  );
endinterface

// File: rtl/pipe_id_ex_nlane.sv
// N-lane ID/EX pipeline register with ready/valid handshake.
// Optional macro ID_EX_SKID_EN adds a 2-entry skid with registered in_ready.
module pipe_id_ex_nlane #(
  parameter int LANES        = 2,
  parameter int PAY_W        = 118,
  parameter bit ZERO_INVALID = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  pipe_id_ex_nlane_if.slave bus
);

  localparam int BW = LANES * PAY_W;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       occ_q, occ_d;
  logic [LANES-1:0] main_v_q, main_v_d;
  logic [BW-1:0]    main_p_q, main_p_d;
  logic [LANES-1:0] cap_v;
  logic [BW-1:0]    cap_p;
  logic             push, alloc, pop;

  // Masked lane valids and zeroed payload of the incoming bundle
  always_comb begin
    cap_v = bus.in_valid & ~bus.kill_mask
          & {LANES{bus.redirect == 2'b00}};
    cap_p = '0;
    for (int i = 0; i < LANES; i++) begin
      if (ZERO_INVALID && !cap_v[i])
        cap_p[i*PAY_W +: PAY_W] = '0;
      else
        cap_p[i*PAY_W +: PAY_W] = bus.in_pay[i*PAY_W +: PAY_W];
    end
  end

  assign push  = bus.in_ready & (|bus.in_valid);
  assign alloc = push & (|cap_v);
  assign pop   = bus.out_ready & (|main_v_q);

  assign bus.out_valid = main_v_q;
  assign bus.out_pay   = main_p_q;
  assign bus.occ       = occ_q;

`ifdef ID_EX_SKID_EN

  logic [LANES-1:0] skid_v_q, skid_v_d;
  logic [BW-1:0]    skid_p_q, skid_p_d;
  logic             in_ready_q, in_ready_d;

  assign bus.in_ready = in_ready_q;

  // Occupancy FSM: head in main, overflow in skid
  always_comb begin
    occ_d    = occ_q;
    main_v_d = main_v_q;
    main_p_d = main_p_q;
    skid_v_d = skid_v_q;
    skid_p_d = skid_p_q;
    if (bus.flush) begin
      occ_d    = S_EMPTY;
      main_v_d = '0;
      skid_v_d = '0;
    end else begin
      case (occ_q)
        S_EMPTY: begin
          if (alloc) begin
            main_v_d = cap_v;
            main_p_d = cap_p;
            occ_d    = S_ONE;
          end
        end
        S_ONE: begin
          if (alloc && !pop) begin
            skid_v_d = cap_v;
            skid_p_d = cap_p;
            occ_d    = S_TWO;
          end else if (alloc && pop) begin
            main_v_d = cap_v;
            main_p_d = cap_p;
          end else if (pop) begin
            main_v_d = '0;
            occ_d    = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            main_v_d = skid_v_q;
            main_p_d = skid_p_q;
            skid_v_d = '0;
            occ_d    = S_ONE;
          end
        end
        default: begin
          occ_d    = S_EMPTY;
          main_v_d = '0;
          skid_v_d = '0;
        end
      endcase
    end
    in_ready_d = (occ_d != S_TWO);
  end

  // Skid storage and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v_q   <= '0;
      skid_p_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      skid_v_q   <= skid_v_d;
      skid_p_q   <= skid_p_d;
      in_ready_q <= in_ready_d;
    end
  end

`else

  assign bus.in_ready = (occ_q == S_EMPTY) | bus.out_ready;

  // Single-entry FSM: refill on pop, drain when idle
  always_comb begin
    occ_d    = occ_q;
    main_v_d = main_v_q;
    main_p_d = main_p_q;
    if (bus.flush) begin
      occ_d    = S_EMPTY;
      main_v_d = '0;
    end else if (alloc) begin
      main_v_d = cap_v;
      main_p_d = cap_p;
      occ_d    = S_ONE;
    end else if (pop) begin
      main_v_d = '0;
      occ_d    = S_EMPTY;
    end
  end

`endif

  // Head entry and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= S_EMPTY;
      main_v_q <= '0;
      main_p_q <= '0;
    end else begin
      occ_q    <= occ_d;
      main_v_q <= main_v_d;
      main_p_q <= main_p_d;
    end
  end

endmodule

// File: tb/tb_pipe_id_ex_nlane.sv
// Bench for pipe_id_ex_nlane: directed steps, scoreboard of held bundles.
// Skid-specific steps are selected by ID_EX_SKID_EN.
module tb_pipe_id_ex_nlane;

  localparam int L  = 2;
  localparam int PW = 118;
  localparam int BW = L * PW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;

  logic [L-1:0]  qv[$];
  logic [BW-1:0] qp[$];

  pipe_id_ex_nlane_if #(.LANES(L), .PAY_W(PW)) bus ();

  pipe_id_ex_nlane #(
    .LANES(L), .PAY_W(PW), .ZERO_INVALID(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rndp();
    logic [BW-1:0] r;
    for (int i = 0; i < BW; i++) r[i] = 1'($urandom_range(1));
    return r;
  endfunction

  function automatic logic [BW-1:0] mpay(input logic [L-1:0] v,
                                         input logic [BW-1:0] p);
    logic [BW-1:0] r;
    r = p;
    for (int i = 0; i < L; i++)
      if (!v[i]) r[i*PW +: PW] = '0;
    return r;
  endfunction

  task automatic drv(input logic [L-1:0] v, input logic [L-1:0] k,
                     input logic [1:0] rd, input logic fl,
                     input logic ordy);
    bus.in_valid  = v;
    bus.kill_mask = k;
    bus.redirect  = rd;
    bus.flush     = fl;
    bus.out_ready = ordy;
    bus.in_pay    = rndp();
  endtask

  // Check outputs against the model, update the model, advance one clock.
  task automatic cyc();
    logic         er;
    logic [L-1:0] cv;
    #1;
    chk("occ", 256'(bus.occ), 256'(qv.size()));
`ifdef ID_EX_SKID_EN
    er = (qv.size() != 2);
`else
    er = (qv.size() == 0) || bus.out_ready;
`endif
    chk("in_ready", 256'(bus.in_ready), 256'(er));
    if (qv.size() > 0) begin
      chk("out_valid", 256'(bus.out_valid), 256'(qv[0]));
      chk("out_pay", 256'(bus.out_pay), 256'(qp[0]));
    end else begin
      chk("out_valid_idle", 256'(bus.out_valid), 256'(0));
    end
    if (bus.flush) begin
      qv.delete();
      qp.delete();
    end else begin
      if (bus.out_ready && qv.size() > 0) begin
        void'(qv.pop_front());
        void'(qp.pop_front());
      end
      cv = bus.in_valid & ~bus.kill_mask
         & {L{bus.redirect == 2'b00}};
      if (er && |bus.in_valid && |cv) begin
        qv.push_back(cv);
        qp.push_back(mpay(cv, bus.in_pay));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_occ", 256'(bus.occ), 256'(0));
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("rst_out_pay", 256'(bus.out_pay), 256'(0));
    rst_n = 1'b1;

    // stream four full bundles with EX always ready
    for (int i = 0; i < 4; i++) begin
      drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
      cyc();
    end
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc();
    cyc();

    // kill lane1, then lane0 only, then redirect
    drv(2'b11, 2'b10, 2'b00, 1'b0, 1'b0);
    cyc();
    drv(2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
`ifdef ID_EX_SKID_EN
    cyc();
    drv(2'b11, 2'b00, 2'b01, 1'b0, 1'b0);
    cyc();
    drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc();
`else
    cyc();
    drv(2'b11, 2'b00, 2'b10, 1'b0, 1'b1);
    cyc();
    drv(2'b11, 2'b00, 2'b01, 1'b0, 1'b0);
    cyc();
    drv(2'b11, 2'b11, 2'b00, 1'b0, 1'b0);
    cyc();
`endif
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc();
    cyc();
    cyc();

    // backpressure
`ifdef ID_EX_SKID_EN
    for (int i = 0; i < 3; i++) begin
      drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
      cyc();
    end
    chk("bp_in_ready_low", 256'(bus.in_ready), 256'(0));
    chk("bp_occ_two", 256'(bus.occ), 256'(2));
    drv(bus.in_valid, 2'b00, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc();
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc();
`else
    drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc();
    drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    #1;
    chk("bp_in_ready_low", 256'(bus.in_ready), 256'(0));
    cyc();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 256'(bus.in_ready), 256'(1));
    for (int i = 0; i < 3; i++) begin
      drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b1);
      cyc();
    end
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc();
    cyc();
`endif

    // flush with push and pop active, then flush with redirect
    drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc();
`ifdef ID_EX_SKID_EN
    drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc();
`endif
    drv(2'b11, 2'b00, 2'b00, 1'b1, 1'b1);
    cyc();
    chk("flush_occ", 256'(bus.occ), 256'(0));
    chk("flush_out_valid", 256'(bus.out_valid), 256'(0));
    drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc();
    drv(2'b11, 2'b00, 2'b11, 1'b1, 1'b0);
    cyc();
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc();

    // async reset mid-stream with entries held
    drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    cyc();
`ifdef ID_EX_SKID_EN
    cyc();
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", 256'(bus.occ), 256'(0));
    chk("arst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("arst_in_ready", 256'(bus.in_ready), 256'(1));
    qv.delete();
    qp.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drv(2'b01, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc();
    drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
